// File: rtl/bp_fe_pkg.sv
// Shared FE definitions: cache service packet layouts, memory command struct and
// the fill engine state encoding used by both the engine and the FE test harness.
package bp_fe_pkg;

  localparam int paddr_width_p        = 40;
  localparam int ptag_width_p         = paddr_width_p - 12;
  localparam int icache_sets_p        = 64;
  localparam int icache_assoc_p       = 8;
  localparam int icache_block_width_p = 512;
  localparam int icache_fill_width_p  = 128;

  localparam int beats_lp             = icache_block_width_p / icache_fill_width_p;
  localparam int index_width_lp       = $clog2(icache_sets_p);
  localparam int way_id_width_lp      = $clog2(icache_assoc_p);
  localparam int fill_index_width_lp  = $clog2(beats_lp);
  localparam int block_offset_width_lp = $clog2(icache_block_width_p / 8);

  typedef enum logic [1:0] {
    e_miss_load = 2'b00,
    e_uc_load   = 2'b01
  } cache_req_msg_e;

  typedef struct packed {
    cache_req_msg_e             msg_type;
    logic [paddr_width_p-1:0]   addr;
    logic [1:0]                 size;
  } icache_req_s;

  typedef enum logic [1:0] {
    e_fill = 2'b00,
    e_uc   = 2'b01
  } data_mem_opcode_e;

  typedef enum logic [1:0] {
    e_tag_set = 2'b00
  } tag_mem_opcode_e;

  typedef enum logic [1:0] {
    e_invalid = 2'b00,
    e_valid   = 2'b01
  } coh_state_e;

  typedef enum logic [1:0] {
    e_set_lru = 2'b00
  } stat_mem_opcode_e;

  typedef struct packed {
    data_mem_opcode_e                opcode;
    logic [index_width_lp-1:0]       index;
    logic [way_id_width_lp-1:0]      way_id;
    logic [fill_index_width_lp-1:0]  fill_index;
    logic [icache_fill_width_p-1:0]  data;
  } data_mem_pkt_s;

  typedef struct packed {
    tag_mem_opcode_e                 opcode;
    logic [index_width_lp-1:0]       index;
    logic [way_id_width_lp-1:0]      way_id;
    logic [ptag_width_p-1:0]         tag;
    coh_state_e                      state;
  } tag_mem_pkt_s;

  typedef struct packed {
    stat_mem_opcode_e                opcode;
    logic [index_width_lp-1:0]       index;
    logic [way_id_width_lp-1:0]      way_id;
  } stat_mem_pkt_s;

  typedef struct packed {
    logic [paddr_width_p-1:0]        addr;
    logic                            uncached;
  } mem_cmd_s;

  typedef enum logic [2:0] {
    e_st_idle      = 3'd0,
    e_st_wait_meta = 3'd1,
    e_st_send_cmd  = 3'd2,
    e_st_fill      = 3'd3,
    e_st_uc_data   = 3'd4,
    e_st_tag       = 3'd5,
    e_st_stat      = 3'd6,
    e_st_done      = 3'd7
  } fill_state_e;

  function automatic logic [paddr_width_p-1:0] block_align(input logic [paddr_width_p-1:0] addr);
    return {addr[paddr_width_p-1:block_offset_width_lp], {block_offset_width_lp{1'b0}}};
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear that wraps to zero after max_val_p.
module bsg_counter_clear_up #(
  parameter int max_val_p = 3,
  parameter int width_p   = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (up_i) begin
      if (count_o == width_p'(max_val_p)) count_o <= '0;
      else                                count_o <= count_o + width_p'(1);
    end
  end

endmodule

// File: rtl/bp_fe_icache_fill_engine.sv
// I-cache miss responder: takes one request plus victim way, fetches the block
// (or one uncached word) from memory and writes data, tag and LRU back to the cache.
module bp_fe_icache_fill_engine
  import bp_fe_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            reset_i,

  input  icache_req_s                     cache_req_i,
  input  logic                            cache_req_v_i,
  output logic                            cache_req_ready_o,
  input  logic [way_id_width_lp-1:0]      cache_req_metadata_i,
  input  logic                            cache_req_metadata_v_i,
  output logic                            cache_req_complete_o,
  output logic                            cache_req_critical_o,

  output data_mem_pkt_s                   data_mem_pkt_o,
  output logic                            data_mem_pkt_v_o,
  input  logic                            data_mem_pkt_ready_i,

  output tag_mem_pkt_s                    tag_mem_pkt_o,
  output logic                            tag_mem_pkt_v_o,
  input  logic                            tag_mem_pkt_ready_i,

  output stat_mem_pkt_s                   stat_mem_pkt_o,
  output logic                            stat_mem_pkt_v_o,
  input  logic                            stat_mem_pkt_ready_i,

  output mem_cmd_s                        mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,

  input  logic [icache_fill_width_p-1:0]  mem_resp_data_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,

  output fill_state_e                     state_o
);

  localparam logic [fill_index_width_lp-1:0] last_beat_lp = fill_index_width_lp'(beats_lp - 1);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high.
  // Once valid is raised, it and its payload stay put until that transfer occurs.
  // mem_resp uses valid/yumi: yumi is only raised in a cycle where valid is high.

  fill_state_e                     state_r, state_n;
  logic [paddr_width_p-1:0]        addr_r;
  logic                            uc_r;
  logic [way_id_width_lp-1:0]      way_r;
  logic [fill_index_width_lp-1:0]  beat_cnt;
  logic                            latch_req, latch_way;
  logic                            cnt_clear, cnt_up;
  logic [1:0]                      unused_size;

  assign unused_size = cache_req_i.size;
  assign state_o     = state_r;

  bsg_counter_clear_up #(
    .max_val_p (beats_lp - 1),
    .width_p   (fill_index_width_lp)
  ) beat_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (cnt_clear),
    .up_i    (cnt_up),
    .count_o (beat_cnt)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= e_st_idle;
      addr_r  <= '0;
      uc_r    <= 1'b0;
      way_r   <= '0;
    end else begin
      state_r <= state_n;
      if (latch_req) begin
        addr_r <= cache_req_i.addr;
        uc_r   <= (cache_req_i.msg_type == e_uc_load);
      end
      if (latch_way) way_r <= cache_req_metadata_i;
    end
  end

  always_comb begin
    state_n              = state_r;
    cache_req_ready_o    = 1'b0;
    cache_req_complete_o = 1'b0;
    cache_req_critical_o = 1'b0;
    data_mem_pkt_v_o     = 1'b0;
    tag_mem_pkt_v_o      = 1'b0;
    stat_mem_pkt_v_o     = 1'b0;
    mem_cmd_v_o          = 1'b0;
    mem_resp_yumi_o      = 1'b0;
    latch_req            = 1'b0;
    latch_way            = 1'b0;
    cnt_clear            = 1'b0;
    cnt_up               = 1'b0;

    case (state_r)
      e_st_idle: begin
        // State resets to idle, so ready is masked while reset is held.
        cache_req_ready_o = reset_i;
        if (cache_req_v_i) begin
          latch_req = 1'b1;
          if (cache_req_i.msg_type == e_uc_load) begin
            state_n = e_st_send_cmd;
          end else if (cache_req_metadata_v_i) begin
            latch_way = 1'b1;
            state_n   = e_st_send_cmd;
          end else begin
            state_n = e_st_wait_meta;
          end
        end
      end
      e_st_wait_meta: begin
        if (cache_req_metadata_v_i) begin
          latch_way = 1'b1;
          state_n   = e_st_send_cmd;
        end
      end
      e_st_send_cmd: begin
        mem_cmd_v_o = 1'b1;
        cnt_clear   = 1'b1;
        if (mem_cmd_ready_i) state_n = uc_r ? e_st_uc_data : e_st_fill;
      end
      e_st_fill: begin
        data_mem_pkt_v_o     = mem_resp_v_i;
        mem_resp_yumi_o      = mem_resp_v_i & data_mem_pkt_ready_i;
        cnt_up               = mem_resp_yumi_o;
        cache_req_critical_o = mem_resp_yumi_o
                             & (beat_cnt == addr_r[block_offset_width_lp-1 -: fill_index_width_lp]);
        if (mem_resp_yumi_o && (beat_cnt == last_beat_lp)) state_n = e_st_tag;
      end
      e_st_uc_data: begin
        data_mem_pkt_v_o     = mem_resp_v_i;
        mem_resp_yumi_o      = mem_resp_v_i & data_mem_pkt_ready_i;
        cache_req_critical_o = mem_resp_yumi_o;
        cache_req_complete_o = mem_resp_yumi_o;
        if (mem_resp_yumi_o) state_n = e_st_idle;
      end
      e_st_tag: begin
        tag_mem_pkt_v_o = 1'b1;
        if (tag_mem_pkt_ready_i) state_n = e_st_stat;
      end
      e_st_stat: begin
        stat_mem_pkt_v_o = 1'b1;
        if (stat_mem_pkt_ready_i) state_n = e_st_done;
      end
      e_st_done: begin
        cache_req_complete_o = 1'b1;
        state_n              = e_st_idle;
      end
      default: state_n = e_st_idle;
    endcase
  end

  // Uncached words carry way 0: no victim way is collected for them.
  always_comb begin
    data_mem_pkt_o.opcode     = uc_r ? e_uc : e_fill;
    data_mem_pkt_o.index      = addr_r[block_offset_width_lp +: index_width_lp];
    data_mem_pkt_o.way_id     = uc_r ? '0 : way_r;
    data_mem_pkt_o.fill_index = uc_r ? addr_r[block_offset_width_lp-1 -: fill_index_width_lp] : beat_cnt;
    data_mem_pkt_o.data       = mem_resp_data_i;

    tag_mem_pkt_o.opcode      = e_tag_set;
    tag_mem_pkt_o.index       = addr_r[block_offset_width_lp +: index_width_lp];
    tag_mem_pkt_o.way_id      = way_r;
    tag_mem_pkt_o.tag         = addr_r[paddr_width_p-1 -: ptag_width_p];
    tag_mem_pkt_o.state       = e_valid;

    stat_mem_pkt_o.opcode     = e_set_lru;
    stat_mem_pkt_o.index      = addr_r[block_offset_width_lp +: index_width_lp];
    stat_mem_pkt_o.way_id     = way_r;

    mem_cmd_o.addr            = uc_r ? addr_r : block_align(addr_r);
    mem_cmd_o.uncached        = uc_r;
  end

endmodule

// File: tb/tb_bp_fe_icache_fill_engine.sv
// Directed bench for the I-cache fill engine: table of requests with hand-computed
// packets, a responding memory model, scoreboard queues and a few reset/b2b sequences.
module tb_bp_fe_icache_fill_engine;
  import bp_fe_pkg::*;

  localparam int dw = $bits(data_mem_pkt_s);
  localparam int tw = $bits(tag_mem_pkt_s);
  localparam int sw = $bits(stat_mem_pkt_s);
  localparam int cw = $bits(mem_cmd_s);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- DUT ----------------
  icache_req_s                    cache_req_i;
  logic                           cache_req_v_i, cache_req_ready_o;
  logic [way_id_width_lp-1:0]     cache_req_metadata_i;
  logic                           cache_req_metadata_v_i;
  logic                           cache_req_complete_o, cache_req_critical_o;
  data_mem_pkt_s                  data_mem_pkt_o;
  logic                           data_mem_pkt_v_o, data_mem_pkt_ready_i;
  tag_mem_pkt_s                   tag_mem_pkt_o;
  logic                           tag_mem_pkt_v_o, tag_mem_pkt_ready_i;
  stat_mem_pkt_s                  stat_mem_pkt_o;
  logic                           stat_mem_pkt_v_o, stat_mem_pkt_ready_i;
  mem_cmd_s                       mem_cmd_o;
  logic                           mem_cmd_v_o, mem_cmd_ready_i;
  logic [icache_fill_width_p-1:0] mem_resp_data_i;
  logic                           mem_resp_v_i, mem_resp_yumi_o;
  fill_state_e                    state_o;

  bp_fe_icache_fill_engine dut (
    .clk_i                  (clk),
    .reset_i                (reset_i),
    .cache_req_i            (cache_req_i),
    .cache_req_v_i          (cache_req_v_i),
    .cache_req_ready_o      (cache_req_ready_o),
    .cache_req_metadata_i   (cache_req_metadata_i),
    .cache_req_metadata_v_i (cache_req_metadata_v_i),
    .cache_req_complete_o   (cache_req_complete_o),
    .cache_req_critical_o   (cache_req_critical_o),
    .data_mem_pkt_o         (data_mem_pkt_o),
    .data_mem_pkt_v_o       (data_mem_pkt_v_o),
    .data_mem_pkt_ready_i   (data_mem_pkt_ready_i),
    .tag_mem_pkt_o          (tag_mem_pkt_o),
    .tag_mem_pkt_v_o        (tag_mem_pkt_v_o),
    .tag_mem_pkt_ready_i    (tag_mem_pkt_ready_i),
    .stat_mem_pkt_o         (stat_mem_pkt_o),
    .stat_mem_pkt_v_o       (stat_mem_pkt_v_o),
    .stat_mem_pkt_ready_i   (stat_mem_pkt_ready_i),
    .mem_cmd_o              (mem_cmd_o),
    .mem_cmd_v_o            (mem_cmd_v_o),
    .mem_cmd_ready_i        (mem_cmd_ready_i),
    .mem_resp_data_i        (mem_resp_data_i),
    .mem_resp_v_i           (mem_resp_v_i),
    .mem_resp_yumi_o        (mem_resp_yumi_o),
    .state_o                (state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [159:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected transfer %h (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [127:0] beat_data(input logic [39:0] a, input int i);
    return {a, 8'(i), a, 8'(i), 16'hC0DE, 16'(i)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [dw-1:0] exp_data_q[$];
  logic [tw-1:0] exp_tag_q[$];
  logic [sw-1:0] exp_stat_q[$];
  logic [cw-1:0] exp_cmd_q[$];

  logic        stall_en = 1'b0;
  logic        exp_uc_g = 1'b0;
  logic [1:0]  exp_crit_g = '0;
  int cmd_cnt = 0, beat_cnt = 0, tag_cnt = 0, stat_cnt = 0, crit_cnt = 0, comp_cnt = 0;
  int last_comp_cyc = 0;
  int req_cyc = 0;

  // Handshake flags sampled at negedge, consumed by the memory model next posedge.
  logic        cmd_fire_s = 1'b0, yumi_s = 1'b0;
  mem_cmd_s    cmd_s;

  logic hold_d = 1'b0, hold_t = 1'b0, hold_s = 1'b0, hold_c = 1'b0;
  data_mem_pkt_s held_d;
  tag_mem_pkt_s  held_t;
  stat_mem_pkt_s held_s;
  mem_cmd_s      held_c;

  always @(negedge clk) begin
    if (!reset_i) begin
      hold_d = 1'b0; hold_t = 1'b0; hold_s = 1'b0; hold_c = 1'b0;
      cmd_fire_s = 1'b0; yumi_s = 1'b0;
    end else begin
      if (mem_cmd_v_o && mem_cmd_ready_i) begin
        cmd_cnt++;
        if (exp_cmd_q.size() == 0) unexpected("mem_cmd_extra", 160'(mem_cmd_o));
        else check("mem_cmd", 160'(mem_cmd_o), 160'(exp_cmd_q.pop_front()));
      end
      if (data_mem_pkt_v_o && data_mem_pkt_ready_i) begin
        beat_cnt++;
        if (exp_data_q.size() == 0) unexpected("data_pkt_extra", 160'(data_mem_pkt_o));
        else check("data_pkt", 160'(data_mem_pkt_o), 160'(exp_data_q.pop_front()));
      end
      if (tag_mem_pkt_v_o && tag_mem_pkt_ready_i) begin
        tag_cnt++;
        if (exp_tag_q.size() == 0) unexpected("tag_pkt_extra", 160'(tag_mem_pkt_o));
        else check("tag_pkt", 160'(tag_mem_pkt_o), 160'(exp_tag_q.pop_front()));
      end
      if (stat_mem_pkt_v_o && stat_mem_pkt_ready_i) begin
        stat_cnt++;
        if (exp_stat_q.size() == 0) unexpected("stat_pkt_extra", 160'(stat_mem_pkt_o));
        else check("stat_pkt", 160'(stat_mem_pkt_o), 160'(exp_stat_q.pop_front()));
      end
      if (cache_req_critical_o) begin
        crit_cnt++;
        check("critical_on_fire", 160'(data_mem_pkt_v_o & data_mem_pkt_ready_i), 160'(1));
        check("critical_beat", 160'(data_mem_pkt_o.fill_index), 160'(exp_crit_g));
      end
      if (cache_req_complete_o) begin
        comp_cnt++;
        last_comp_cyc = cyc;
        check("critical_with_complete", 160'(cache_req_critical_o), 160'(exp_uc_g));
      end
      if (hold_d && data_mem_pkt_v_o) check("data_stable", 160'(data_mem_pkt_o), 160'(held_d));
      if (hold_t && tag_mem_pkt_v_o)  check("tag_stable", 160'(tag_mem_pkt_o), 160'(held_t));
      if (hold_s && stat_mem_pkt_v_o) check("stat_stable", 160'(stat_mem_pkt_o), 160'(held_s));
      if (hold_c && mem_cmd_v_o)      check("cmd_stable", 160'(mem_cmd_o), 160'(held_c));
      hold_d = data_mem_pkt_v_o & ~data_mem_pkt_ready_i;  held_d = data_mem_pkt_o;
      hold_t = tag_mem_pkt_v_o & ~tag_mem_pkt_ready_i;    held_t = tag_mem_pkt_o;
      hold_s = stat_mem_pkt_v_o & ~stat_mem_pkt_ready_i;  held_s = stat_mem_pkt_o;
      hold_c = mem_cmd_v_o & ~mem_cmd_ready_i;            held_c = mem_cmd_o;
      cmd_fire_s = mem_cmd_v_o & mem_cmd_ready_i;
      cmd_s      = mem_cmd_o;
      yumi_s     = mem_resp_v_i & mem_resp_yumi_o;
    end
  end

  // ---------------- memory model and ready drivers ----------------
  logic        mem_active = 1'b0;
  logic [39:0] mem_addr = '0;
  int          mem_beats = 0, mem_idx = 0;

  always @(posedge clk) begin
    #1;
    if (!reset_i) begin
      mem_active = 1'b0;
      mem_resp_v_i = 1'b0;
      data_mem_pkt_ready_i = 1'b1; tag_mem_pkt_ready_i = 1'b1;
      stat_mem_pkt_ready_i = 1'b1; mem_cmd_ready_i = 1'b1;
    end else begin
      if (yumi_s) begin
        mem_idx++;
        if (mem_idx == mem_beats) mem_active = 1'b0;
      end
      if (cmd_fire_s) begin
        mem_active = 1'b1;
        mem_addr   = cmd_s.addr;
        mem_beats  = cmd_s.uncached ? 1 : beats_lp;
        mem_idx    = 0;
      end
      if (!mem_resp_v_i || yumi_s)
        mem_resp_v_i = mem_active && (!stall_en || ($urandom_range(0, 2) != 0));
      mem_resp_data_i      = beat_data(mem_addr, mem_idx);
      data_mem_pkt_ready_i = !stall_en || ($urandom_range(0, 3) != 0);
      tag_mem_pkt_ready_i  = !stall_en || ($urandom_range(0, 2) != 0);
      stat_mem_pkt_ready_i = !stall_en || ($urandom_range(0, 2) != 0);
      mem_cmd_ready_i      = !stall_en || ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        uc;
    logic [39:0] addr;
    logic [2:0]  way;
    int          meta_delay;
    logic        stall;
    logic [39:0] exp_cmd_addr;
    logic [5:0]  exp_index;
    logic [27:0] exp_tag;
    logic [1:0]  exp_crit;
    int          exp_lat;     // 0 when stalls make latency variable
  } vec_t;

  vec_t vecs[7];

  task automatic push_expect(input vec_t v);
    data_mem_pkt_s dp;
    tag_mem_pkt_s  tp;
    stat_mem_pkt_s spk;
    mem_cmd_s      mc;
    stall_en   = v.stall;
    exp_uc_g   = v.uc;
    exp_crit_g = v.exp_crit;
    mc.addr = v.exp_cmd_addr;
    mc.uncached = v.uc;
    exp_cmd_q.push_back(mc);
    for (int i = 0; i < (v.uc ? 1 : beats_lp); i++) begin
      dp.opcode     = v.uc ? e_uc : e_fill;
      dp.index      = v.exp_index;
      dp.way_id     = v.uc ? 3'd0 : v.way;
      dp.fill_index = v.uc ? v.exp_crit : 2'(i);
      dp.data       = beat_data(v.exp_cmd_addr, i);
      exp_data_q.push_back(dp);
    end
    if (!v.uc) begin
      tp.opcode = e_tag_set; tp.index = v.exp_index; tp.way_id = v.way;
      tp.tag = v.exp_tag; tp.state = e_valid;
      exp_tag_q.push_back(tp);
      spk.opcode = e_set_lru; spk.index = v.exp_index; spk.way_id = v.way;
      exp_stat_q.push_back(spk);
    end
  endtask

  // Drives request (+ metadata) at posedge+1; returns at posedge+1 after completion.
  task automatic drive_req(input vec_t v);
    cache_req_i.msg_type   = v.uc ? e_uc_load : e_miss_load;
    cache_req_i.addr       = v.addr;
    cache_req_i.size       = 2'b11;
    cache_req_v_i          = 1'b1;
    cache_req_metadata_v_i = (v.meta_delay == 0);
    cache_req_metadata_i   = (v.meta_delay == 0) ? v.way : ~v.way;
    req_cyc = cyc;
    @(posedge clk); #1;
    cache_req_metadata_v_i = 1'b0;
    if (v.meta_delay > 0) begin
      // A competing request while waiting for metadata must be ignored.
      cache_req_i.msg_type = e_uc_load;
      cache_req_i.addr     = 40'hDE_ADBE_EF00;
      for (int d = 1; d < v.meta_delay; d++) begin
        check("wait_meta_state", 160'(state_o), 160'(e_st_wait_meta));
        check("no_early_cmd", 160'(mem_cmd_v_o), 160'(0));
        @(posedge clk); #1;
      end
      check("wait_meta_state", 160'(state_o), 160'(e_st_wait_meta));
      cache_req_metadata_v_i = 1'b1;
      cache_req_metadata_i   = v.way;
      @(posedge clk); #1;
      cache_req_metadata_v_i = 1'b0;
      cache_req_metadata_i   = ~v.way;
    end
    cache_req_v_i = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int c0, b0, t0, s0, k0, r0, m0, k;
    c0 = comp_cnt; b0 = beat_cnt; t0 = tag_cnt; s0 = stat_cnt; k0 = crit_cnt; m0 = cmd_cnt;
    r0 = 0;
    push_expect(v);
    check("ready_before_req", 160'(cache_req_ready_o), 160'(1));
    drive_req(v);
    k = 0;
    while (comp_cnt == c0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("complete_count", 160'(comp_cnt - c0), 160'(1));
    if (v.exp_lat != 0) check("latency", 160'(last_comp_cyc - req_cyc), 160'(v.exp_lat));
    check("ready_after_complete", 160'(cache_req_ready_o), 160'(1));
    check("idle_after_complete", 160'(state_o), 160'(e_st_idle));
    check("cmd_count", 160'(cmd_cnt - m0), 160'(1));
    check("beat_count", 160'(beat_cnt - b0), 160'(v.uc ? 1 : beats_lp));
    check("tag_count", 160'(tag_cnt - t0), 160'(v.uc ? 0 : 1));
    check("stat_count", 160'(stat_cnt - s0), 160'(v.uc ? 0 : 1));
    check("critical_count", 160'(crit_cnt - k0 + r0), 160'(1));
    check("data_q_drained", 160'(exp_data_q.size()), 160'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_comp, comp_before;
    //            uc    addr               way  dly stall cmd_addr           index  tag            crit lat
    vecs[0] = '{1'b0, 40'h00_8000_1234, 3'd5, 0, 1'b0, 40'h00_8000_1200, 6'h08, 28'h0080001, 2'd3, 8};
    vecs[1] = '{1'b0, 40'h00_8000_1234, 3'd2, 3, 1'b0, 40'h00_8000_1200, 6'h08, 28'h0080001, 2'd3, 11};
    vecs[2] = '{1'b1, 40'h00_0010_1008, 3'd4, 0, 1'b0, 40'h00_0010_1008, 6'h00, 28'h0000000, 2'd0, 2};
    vecs[3] = '{1'b0, 40'h00_0000_0010, 3'd0, 0, 1'b0, 40'h00_0000_0000, 6'h00, 28'h0000000, 2'd1, 8};
    vecs[4] = '{1'b0, 40'hFF_FFFF_FFE0, 3'd7, 1, 1'b1, 40'hFF_FFFF_FFC0, 6'h3F, 28'hFFFFFFF, 2'd2, 0};
    vecs[5] = '{1'b1, 40'h12_3456_7ABC, 3'd3, 0, 1'b1, 40'h12_3456_7ABC, 6'h2A, 28'h0000000, 2'd3, 0};
    vecs[6] = '{1'b0, 40'h00_8000_1234, 3'd5, 2, 1'b1, 40'h00_8000_1200, 6'h08, 28'h0080001, 2'd3, 0};

    reset_i = 1'b0;
    cache_req_i = '0; cache_req_v_i = 1'b0;
    cache_req_metadata_i = '0; cache_req_metadata_v_i = 1'b0;
    data_mem_pkt_ready_i = 1'b1; tag_mem_pkt_ready_i = 1'b1;
    stat_mem_pkt_ready_i = 1'b1; mem_cmd_ready_i = 1'b1;
    mem_resp_v_i = 1'b0; mem_resp_data_i = '0;

    #2;
    check("reset_ready", 160'(cache_req_ready_o), 160'(0));
    check("reset_valids", 160'({data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o, mem_cmd_v_o,
                                mem_resp_yumi_o, cache_req_complete_o, cache_req_critical_o}), 160'(0));
    check("reset_state", 160'(state_o), 160'(e_st_idle));
    repeat (3) @(posedge clk);
    #3 reset_i = 1'b1;
    @(posedge clk); #1;
    check("ready_first_cycle", 160'(cache_req_ready_o), 160'(1));

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Back-to-back: second request goes in the cycle right after complete.
    run_txn(vecs[0]);
    saved_comp = last_comp_cyc;
    run_txn(vecs[3]);
    check("b2b_accept_gap", 160'(req_cyc - saved_comp), 160'(1));

    // Reset while beat 2 is on the data port.
    comp_before = comp_cnt;
    push_expect(vecs[0]);
    drive_req(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("beat2_valid", 160'(data_mem_pkt_v_o), 160'(1));
    check("beat2_index", 160'(data_mem_pkt_o.fill_index), 160'(2));
    #2 reset_i = 1'b0;
    #1;
    check("abort_valids", 160'({data_mem_pkt_v_o, tag_mem_pkt_v_o, stat_mem_pkt_v_o, mem_cmd_v_o,
                                mem_resp_yumi_o, cache_req_complete_o, cache_req_critical_o}), 160'(0));
    check("abort_ready", 160'(cache_req_ready_o), 160'(0));
    check("abort_state", 160'(state_o), 160'(e_st_idle));
    exp_data_q.delete(); exp_tag_q.delete(); exp_stat_q.delete(); exp_cmd_q.delete();
    repeat (2) @(posedge clk);
    #3 reset_i = 1'b1;
    @(posedge clk); #1;
    check("ready_after_abort", 160'(cache_req_ready_o), 160'(1));
    check("no_partial_complete", 160'(comp_cnt - comp_before), 160'(0));
    run_txn(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
